// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game sequencer: state encodings,
// score ceiling, default timing parameters and a saturating score increment.
package whack_pkg;

  typedef enum logic [1:0] {
    ST_COUNTDOWN = 2'd0,
    ST_PLAY      = 2'd1,
    ST_OVER      = 2'd2
  } state_t;

  localparam logic [13:0] SCORE_MAX     = 14'd9999;
  localparam int          DEF_COUNT_SEC = 5;
  localparam int          DEF_GAME_SEC  = 30;
  localparam int          DEF_MOLE_SEC  = 2;

  // Score stays pinned at the four-digit display ceiling.
  function automatic logic [13:0] score_inc(input logic [13:0] value);
    return (value >= SCORE_MAX) ? SCORE_MAX : value + 14'd1;
  endfunction

endpackage

// File: rtl/hit_edge_detect.sv
// Rising-edge detector for the hit level. The history register resets high so
// a hit already held when reset releases is never seen as a new edge.
module hit_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic hit,
  output logic hit_rise
);

  logic hit_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q_reg <= 1'b1;
    end else begin
      hit_q_reg <= hit;
    end
  end

  assign hit_rise = hit & ~hit_q_reg;

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: countdown, timed play phase with mole refresh and
// scoring, then a frozen game-over state until start is requested.
module game_sequencer
  import whack_pkg::*;
#(
  parameter int COUNT_SEC = DEF_COUNT_SEC,
  parameter int GAME_SEC  = DEF_GAME_SEC,
  parameter int MOLE_SEC  = DEF_MOLE_SEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        hit,
  input  logic        start,
  output logic [1:0]  state_o,
  output logic        game_begin,
  output logic [3:0]  countdown,
  output logic [4:0]  time_left,
  output logic [13:0] score,
  output logic        mole_next,
  output logic        mole_en
);

  localparam int               AGE_W    = (MOLE_SEC > 1) ? $clog2(MOLE_SEC) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(MOLE_SEC - 1);
  localparam logic [3:0]       CD_INIT  = 4'(COUNT_SEC);
  localparam logic [4:0]       TL_INIT  = 5'(GAME_SEC);

  state_t           state_reg;
  logic [AGE_W-1:0] age_reg;
  logic             hit_rise;
  logic             age_timeout;

  hit_edge_detect u_hit_edge_detect (
    .clk      (clk),
    .reset    (reset),
    .hit      (hit),
    .hit_rise (hit_rise)
  );

  assign age_timeout = tick_1hz && (age_reg == AGE_LAST);
  assign state_o     = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_COUNTDOWN;
      countdown  <= CD_INIT;
      time_left  <= TL_INIT;
      score      <= '0;
      game_begin <= 1'b0;
      mole_next  <= 1'b0;
      mole_en    <= 1'b0;
      age_reg    <= '0;
    end else begin
      mole_next <= 1'b0;
      case (state_reg)
        ST_COUNTDOWN: begin
          if (tick_1hz) begin
            if (countdown <= 4'd1) begin
              countdown  <= '0;
              state_reg  <= ST_PLAY;
              game_begin <= 1'b1;
              mole_en    <= 1'b1;
              mole_next  <= 1'b1;
              age_reg    <= '0;
            end else begin
              countdown <= countdown - 4'd1;
            end
          end
        end

        ST_PLAY: begin
          if (hit_rise) begin
            score <= score_inc(score);
          end
          if (tick_1hz && (time_left <= 5'd1)) begin
            // Final tick: a coinciding hit still scores, but no new mole.
            time_left <= '0;
            state_reg <= ST_OVER;
            mole_en   <= 1'b0;
          end else begin
            if (tick_1hz) begin
              time_left <= time_left - 5'd1;
            end
            // A request right after a pulse is absorbed so pulses never abut.
            if (hit_rise || age_timeout) begin
              mole_next <= ~mole_next;
              age_reg   <= '0;
            end else if (tick_1hz) begin
              age_reg <= age_reg + 1'b1;
            end
          end
        end

        ST_OVER: begin
          mole_en <= 1'b0;
          if (start) begin
            state_reg  <= ST_COUNTDOWN;
            countdown  <= CD_INIT;
            time_left  <= TL_INIT;
            score      <= '0;
            game_begin <= 1'b0;
            age_reg    <= '0;
          end
        end

        default: begin
          state_reg  <= ST_COUNTDOWN;
          countdown  <= CD_INIT;
          time_left  <= TL_INIT;
          score      <= '0;
          game_begin <= 1'b0;
          mole_en    <= 1'b0;
          age_reg    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a tick-counting game model is compared
// against every output each cycle, plus hand-computed checkpoints per scenario.
module tb_game_sequencer;

  localparam int COUNT_SEC = 5;
  localparam int GAME_SEC  = 30;
  localparam int MOLE_SEC  = 2;
  localparam int SCORE_CAP = 9999;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        hit      = 1'b0;
  logic        start    = 1'b0;
  logic [1:0]  state_o;
  logic        game_begin;
  logic [3:0]  countdown;
  logic [4:0]  time_left;
  logic [13:0] score;
  logic        mole_next;
  logic        mole_en;

  game_sequencer #(
    .COUNT_SEC (COUNT_SEC),
    .GAME_SEC  (GAME_SEC),
    .MOLE_SEC  (MOLE_SEC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .hit        (hit),
    .start      (start),
    .state_o    (state_o),
    .game_begin (game_begin),
    .countdown  (countdown),
    .time_left  (time_left),
    .score      (score),
    .mole_next  (mole_next),
    .mole_en    (mole_en)
  );

  always #5 clk = ~clk;

  int vectors      = 0;
  int miscompares  = 0;
  int tick_phase   = 0;
  int tick_drv_cnt = 0;
  int pulse_cnt    = 0;
  bit tick_en      = 1'b0;

  // Game model: phase 0 countdown, 1 play, 2 over; times are derived from tick counts.
  bit m_valid      = 1'b0;
  int m_phase      = 0;
  int m_cd_ticks   = 0;
  int m_play_ticks = 0;
  int m_hits       = 0;
  int m_refresh    = 0;
  bit m_prev_hit   = 1'b1;
  bit m_pulse      = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input int act, input int exp);
    check(name, act, exp);
    $display("check %-20s got %0d want %0d", name, act, exp);
  endtask

  always @(posedge clk) begin : model
    bit rise;
    bit req;
    rise = hit && !m_prev_hit;
    req  = 1'b0;
    if (reset) begin
      m_valid      = 1'b1;
      m_phase      = 0;
      m_cd_ticks   = 0;
      m_play_ticks = 0;
      m_hits       = 0;
      m_refresh    = 0;
      m_prev_hit   = 1'b1;
      m_pulse      = 1'b0;
    end else begin
      m_prev_hit = hit;
      case (m_phase)
        0: begin
          if (tick_1hz) begin
            m_cd_ticks++;
            if (m_cd_ticks == COUNT_SEC) begin
              m_phase   = 1;
              m_refresh = 0;
              req       = 1'b1;
            end
          end
        end
        1: begin
          if (rise) m_hits++;
          if (tick_1hz) m_play_ticks++;
          if (tick_1hz && m_play_ticks == GAME_SEC) begin
            m_phase = 2;
          end else if (rise || (tick_1hz && (m_play_ticks - m_refresh) == MOLE_SEC)) begin
            req       = 1'b1;
            m_refresh = m_play_ticks;
          end
        end
        default: begin
          if (start) begin
            m_phase      = 0;
            m_cd_ticks   = 0;
            m_play_ticks = 0;
            m_hits       = 0;
            m_refresh    = 0;
          end
        end
      endcase
      m_pulse = req && !m_pulse;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("state",      state_o,    m_phase);
      check("game_begin", game_begin, (m_phase != 0) ? 1 : 0);
      check("countdown",  countdown,  COUNT_SEC - m_cd_ticks);
      check("time_left",  time_left,  GAME_SEC - m_play_ticks);
      check("score",      score,      (m_hits > SCORE_CAP) ? SCORE_CAP : m_hits);
      check("mole_en",    mole_en,    (m_phase == 1) ? 1 : 0);
      check("mole_next",  mole_next,  m_pulse ? 1 : 0);
      if (mole_next) pulse_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    tick_1hz = tick_en && (tick_phase == 9);
    if (tick_1hz) tick_drv_cnt++;
    tick_phase = (tick_phase + 1) % 10;
  endtask

  task automatic wait_state(input int target, input int limit, input string name);
    int n = 0;
    while (state_o != target && n < limit) begin
      step();
      n++;
    end
    pin(name, state_o, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, p0, t0, n;

    // Reset state
    repeat (3) step();
    pin("rst_state",      state_o,    0);
    pin("rst_countdown",  countdown,  5);
    pin("rst_time_left",  time_left,  30);
    pin("rst_score",      score,      0);
    pin("rst_game_begin", game_begin, 0);
    pin("rst_mole_en",    mole_en,    0);
    reset      = 1'b0;
    tick_en    = 1'b1;
    tick_phase = 0;

    // Countdown into PLAY
    wait_state(1, 80, "enter_play");
    pin("entry_countdown",  countdown,  0);
    pin("entry_game_begin", game_begin, 1);
    pin("entry_mole_next",  mole_next,  1);
    pin("entry_mole_en",    mole_en,    1);

    // Held hit scores once, one cycle after it is first sampled
    s0 = score;
    hit = 1'b1;
    step();
    pin("hit_one_cycle", score, s0 + 1);
    repeat (49) step();
    hit = 1'b0;
    step();
    pin("held_hit_once", score, s0 + 1);

    // Mole timeout after two idle ticks
    hit = 1'b1;
    step();
    p0 = pulse_cnt;
    s0 = score;
    hit = 1'b0;
    t0 = tick_drv_cnt - (tick_1hz ? 1 : 0);
    n = 0;
    while ((tick_drv_cnt - t0) < 2 && n < 100) begin
      step();
      n++;
    end
    step();
    pin("timeout_pulses", pulse_cnt - p0, 1);
    pin("timeout_score",  score,          s0);

    // Hit on the final play tick
    n = 0;
    while (!(time_left == 5'd1 && tick_1hz) && n < 400) begin
      step();
      n++;
    end
    pin("final_tick_found", (time_left == 5'd1 && tick_1hz) ? 1 : 0, 1);
    s0 = score;
    hit = 1'b1;
    step();
    pin("final_state",     state_o,   2);
    pin("final_score",     score,     s0 + 1);
    pin("final_mole_next", mole_next, 0);
    hit = 1'b0;
    step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    pin("over_score_frozen", score,   s0 + 1);
    pin("over_mole_en",      mole_en, 0);

    // start from OVER
    start = 1'b1;
    step();
    start = 1'b0;
    pin("restart_state",      state_o,    0);
    pin("restart_score",      score,      0);
    pin("restart_countdown",  countdown,  5);
    pin("restart_time_left",  time_left,  30);
    pin("restart_game_begin", game_begin, 0);

    // Score saturation with ticks paused
    wait_state(1, 100, "enter_play2");
    tick_en = 1'b0;
    for (int i = 0; i < 9998; i++) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
      step();
    end
    pin("score_9998", score, 9998);
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1;
      step();
      pin("score_sat", score, 9999);
      hit = 1'b0;
      step();
    end
    tick_en = 1'b1;

    // Reset mid-PLAY with time_left 17 and score 4
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_state(1, 100, "enter_play3");
    for (int i = 0; i < 4; i++) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
      step();
    end
    n = 0;
    while (time_left != 5'd17 && n < 300) begin
      step();
      n++;
    end
    pin("mid_time_left", time_left, 17);
    pin("mid_score",     score,     4);
    hit   = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pin("midrst_state",     state_o,   0);
    pin("midrst_countdown", countdown, 5);
    pin("midrst_score",     score,     0);
    pin("midrst_time_left", time_left, 30);

    // Hit held across reset never scores
    wait_state(1, 100, "enter_play4");
    repeat (5) step();
    pin("held_across_reset", score, 0);
    hit = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
